rxfifo: RTL and testbench
=========================

Name: rxfifo

Overview:
- Receive-side buffer of the SSP block, mirroring the transmit FIFO.
- Accepts bytes from the receive logic one per `rx_valid` strobe and stores them in a small circular buffer.
- The bus side drains it via APB-style reads (`PSEL` high, `PWRITE` low).
- Raises `SSPRXINTR` while full so the processor knows to drain it.

Parameters:
- `DATA_W`, 8, width of each entry and of `RxData`/`PRDATA`.
- `ADDR_W`, 2, pointer width; depth = 2**`ADDR_W` (4 entries by default).

Ports:
- `PCLK`  input  1  sole clock; all state changes on rising edge.
- `CLEAR_B`  input  1  reset, synchronous, active-low.
- `PSEL`  input  1  peripheral select from bus.
- `PWRITE`  input  1  bus direction; read when 0.
- `rx_valid`  input  1  receive logic has a completed byte on `RxData` (one-cycle strobe per byte).
- `RxData`  input  `DATA_W`  received byte.
- `PRDATA`  output  `DATA_W`  registered read data to bus.
- `rx_empty`  output  1  high when FIFO holds 0 entries.
- `SSPRXINTR`  output  1  high when FIFO holds 2**`ADDR_W` entries (full).
- `SSPRXOVR`  output  1  sticky overrun flag (see Optional Feature).

Behaviour:
- State: storage array, `wr_ptr` and `rd_ptr` (`ADDR_W` bits, wrap modulo depth), `count` (`ADDR_W`+1 bits, 0..depth).
- Reset, `CLEAR_B`=0 at a rising edge:
  - all storage, pointers and `count` become 0.
  - `PRDATA`=0, `SSPRXOVR`=0.
  - hence `rx_empty`=1, `SSPRXINTR`=0.
  - Reset overrides every other input in that cycle, including mid-transfer.
- `rd_en` = `PSEL` & ~`PWRITE`, sampled each rising edge; no `PENABLE`. Holding `rd_en` for N cycles pops up to N entries.
- Write, `rx_valid`=1 and (not full, or `rd_en` with not empty):
  - `mem[wr_ptr]` <= `RxData`.
  - `wr_ptr` +1 (7→0 style wrap).
- Write when full and no read: byte dropped; storage, pointers and `count` unchanged.
- Read, `rd_en`=1 and not empty:
  - `PRDATA` <= `mem[rd_ptr]`, valid the cycle after the sampling edge (1-cycle latency).
  - `rd_ptr` +1.
- Read when empty: `PRDATA` <= 0; pointers unchanged. No write-through bypass.
- Count update: +1 on write only, −1 on read only, unchanged on both or neither.
- Simultaneous read and write:
  - When full: both succeed; the read returns the old oldest entry; `count` stays at depth; `SSPRXINTR` stays 1.
  - When empty: the write is accepted; the read returns 0; `count` becomes 1.
- Flags: `rx_empty` = (`count`==0) and `SSPRXINTR` = (`count`==depth), both decoded from registered `count` only, so glitch-free.
- `PRDATA` holds its value when no read occurs.
- No `#` delays and no `initial` blocks; fully synthesizable.

Optional Feature:
- Macro `RXFIFO_OVERRUN_EN`.
- Defined:
  - `SSPRXOVR` sets at the edge where `rx_valid`=1, the FIFO is full and `rd_en`=0.
  - Stays set until a successful read (non-empty pop) or reset.
  - Set and clear cannot coincide, since a read while full prevents overrun.
- Undefined: `SSPRXOVR` tied 0; no extra flop. The port list is identical in both builds.

Test Plan:
- Reset then idle → `rx_empty`=1, `SSPRXINTR`=0, `PRDATA`=8'h00, `SSPRXOVR`=0.
- Write 8'hA1, 8'hB2, 8'hC3, 8'hD4 via `rx_valid` → `SSPRXINTR`=1 after 4th edge. Then 4 read cycles → `PRDATA` sequence A1, B2, C3, D4, each one cycle after its read edge; `rx_empty`=1 after the last.
- Fill with 11..14, then `rx_valid` with 8'hEE and no read → 8'hEE dropped; reads return 11..14. `SSPRXOVR`=1 after the drop and 0 after the first read with macro; always 0 without it.
- Full FIFO (21..24), same edge `rd_en`=1 and `rx_valid` with 8'h25 → `PRDATA`=21, `SSPRXINTR` stays 1; subsequent reads 22, 23, 24, 25 (wrap-around exercised).
- Empty FIFO, read with `PSEL`=1, `PWRITE`=0 → `PRDATA`=8'h00, pointers unchanged. Then simultaneous read + write 8'h5A → `PRDATA`=00, `count`=1; next read returns 5A.
- Load 2 entries, drive `CLEAR_B`=0 for one edge with `rx_valid`=1 and `rd_en`=1 → all cleared, `rx_empty`=1, `PRDATA`=0, the incoming byte is not stored.

Source files
------------

// File: rtl/rxfifo.sv
// -----------------------------------------------------------------------------
// rxfifo - receive-side buffer of the SSP block.
//
// Bytes from the receive logic (one per rx_valid strobe) are stored in a
// circular buffer of 2**ADDR_W entries. The bus drains it through APB-style
// reads (PSEL high, PWRITE low, no PENABLE phase), with read data registered
// onto PRDATA one cycle after the sampling edge. SSPRXINTR is high while the
// buffer is full.
//
// Optional feature, macro RXFIFO_OVERRUN_EN:
//   defined   - SSPRXOVR is a sticky flag, set when a byte is dropped because
//               the buffer is full and not being read, cleared by a
//               successful read or by CLEAR_B.
//   undefined - SSPRXOVR is tied low and no flop is built.
// The port list is identical in both builds.
// -----------------------------------------------------------------------------
module rxfifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              PCLK,
  input  logic              CLEAR_B,
  input  logic              PSEL,
  input  logic              PWRITE,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] RxData,
  output logic [DATA_W-1:0] PRDATA,
  output logic              rx_empty,
  output logic              SSPRXINTR,
  output logic              SSPRXOVR
);

  localparam int DEPTH = 1 << ADDR_W;

  // Occupancy value meaning "every entry in use".
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_nxt;

  logic rd_en;
  logic is_empty;
  logic is_full;
  logic do_rd;
  logic do_wr;

  // Both flags decode the registered occupancy only, so they never glitch.
  assign is_empty = (count == '0);
  assign is_full  = (count == FULL_CNT);

  // A read is any selected non-write cycle; only a non-empty read pops.
  assign rd_en = PSEL & ~PWRITE;
  assign do_rd = rd_en & ~is_empty;

  // A full buffer still accepts a byte when the same edge frees an entry.
  assign do_wr = rx_valid & (~is_full | do_rd);

  assign rx_empty  = is_empty;
  assign SSPRXINTR = is_full;

  // Next occupancy: up on write only, down on read only, else unchanged.
  always_comb begin
    // NOTE: the default comes first so every path assigns count_nxt and no
    // latch is inferred when neither case arm matches.
    count_nxt = count;
    case ({do_wr, do_rd})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage array: cleared on reset, written at wr_ptr on an accepted byte.
  always_ff @(posedge PCLK) begin
    if (!CLEAR_B) begin
      // NOTE: the storage is cleared on reset as well as the pointers, so
      // nothing written before CLEAR_B can reappear afterwards.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_wr) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      mem[wr_ptr] <= RxData;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the array depth.
  always_ff @(posedge PCLK) begin
    if (!CLEAR_B) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
    end
  end

  // Registered read data: oldest entry on a pop, zero on an empty read,
  // held otherwise. There is no bypass from RxData.
  always_ff @(posedge PCLK) begin
    if (!CLEAR_B) begin
      PRDATA <= '0;
    end else if (rd_en) begin
      PRDATA <= do_rd ? mem[rd_ptr] : '0;
    end
  end

`ifdef RXFIFO_OVERRUN_EN
  logic ovr_q;

  // Sticky overrun: set when a byte is dropped (full and not being read),
  // cleared by a successful pop. A read while full prevents the drop, so the
  // set and clear conditions never coincide.
  always_ff @(posedge PCLK) begin
    if (!CLEAR_B) begin
      ovr_q <= 1'b0;
    end else if (rx_valid & is_full & ~rd_en) begin
      ovr_q <= 1'b1;
    end else if (do_rd) begin
      ovr_q <= 1'b0;
    end
  end

  assign SSPRXOVR = ovr_q;
`else
  assign SSPRXOVR = 1'b0;
`endif

endmodule

// File: tb/tb_rxfifo.sv
// -----------------------------------------------------------------------------
// tb_rxfifo - scoreboard bench for rxfifo.
//
// The driver applies one input vector per clock and, at the same time, asks a
// queue-based reference model what the DUT must show after that edge; the
// expectation is tagged with the edge number and pushed to a scoreboard
// queue. A separate monitor pops the entry on the following falling edge and
// compares PRDATA and the three flags. Directed sequences come first, then
// randomized traffic with occasional CLEAR_B pulses.
// Honours RXFIFO_OVERRUN_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_rxfifo;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              PCLK = 1'b0;
  logic              CLEAR_B;
  logic              PSEL;
  logic              PWRITE;
  logic              rx_valid;
  logic [DATA_W-1:0] RxData;
  logic [DATA_W-1:0] PRDATA;
  logic              rx_empty;
  logic              SSPRXINTR;
  logic              SSPRXOVR;

  rxfifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .PCLK      (PCLK),
    .CLEAR_B   (CLEAR_B),
    .PSEL      (PSEL),
    .PWRITE    (PWRITE),
    .rx_valid  (rx_valid),
    .RxData    (RxData),
    .PRDATA    (PRDATA),
    .rx_empty  (rx_empty),
    .SSPRXINTR (SSPRXINTR),
    .SSPRXOVR  (SSPRXOVR)
  );

  always #5 PCLK = ~PCLK;

  // Rising-edge counter used to line expectations up with DUT edges.
  int unsigned edge_cnt = 0;
  always @(posedge PCLK) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int unsigned       edge_no;
    logic [DATA_W-1:0] prdata;
    logic              empty;
    logic              full;
    logic              ovr;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: contents as a plain byte queue.
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_prdata = '0;
  logic              m_ovr    = 1'b0;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int unsigned edge_no,
                       input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_no, actual, expected);
    end
  endtask

  // Monitor: compare every expectation whose edge has already happened.
  always @(negedge PCLK) begin
    while (sb_q.size() > 0 && sb_q[0].edge_no <= edge_cnt) begin
      exp_t e;
      e = sb_q.pop_front();
      check("PRDATA",    e.edge_no, 32'(PRDATA),    32'(e.prdata));
      check("rx_empty",  e.edge_no, 32'(rx_empty),  32'(e.empty));
      check("SSPRXINTR", e.edge_no, 32'(SSPRXINTR), 32'(e.full));
      check("SSPRXOVR",  e.edge_no, 32'(SSPRXOVR),  32'(e.ovr));
    end
  end

  // Apply one vector for the next rising edge and record what must follow.
  task automatic step(input logic clr_b, input logic psel, input logic pwrite,
                      input logic rxv, input logic [DATA_W-1:0] d);
    bit   rd;
    int   had;
    bit   popped;
    exp_t e;
    CLEAR_B  = clr_b;
    PSEL     = psel;
    PWRITE   = pwrite;
    rx_valid = rxv;
    RxData   = d;

    if (!clr_b) begin
      m_q.delete();
      m_prdata = '0;
      m_ovr    = 1'b0;
    end else begin
      rd     = psel && !pwrite;
      had    = m_q.size();
      popped = 0;
      if (rd) begin
        if (had > 0) begin
          m_prdata = m_q.pop_front();
          popped   = 1;
        end else begin
          m_prdata = '0;
        end
      end
      if (rxv && (had < DEPTH || popped)) m_q.push_back(d);
`ifdef RXFIFO_OVERRUN_EN
      if (rxv && had == DEPTH && !rd) m_ovr = 1'b1;
      else if (popped)                m_ovr = 1'b0;
`endif
    end

    e.edge_no = edge_cnt + 1;
    e.prdata  = m_prdata;
    e.empty   = (m_q.size() == 0);
    e.full    = (m_q.size() == DEPTH);
    e.ovr     = m_ovr;
    sb_q.push_back(e);

    @(posedge PCLK);
    #1;
  endtask

  task automatic wr(input logic [DATA_W-1:0] d);
    step(1'b1, 1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic rd();
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic rd_wr(input logic [DATA_W-1:0] d);
    step(1'b1, 1'b1, 1'b0, 1'b1, d);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic clear(input logic rxv, input logic rdv);
    step(1'b0, rdv, 1'b0, rxv, 8'h77);
  endtask

  initial begin
    // Reset then idle.
    clear(1'b0, 1'b0);
    clear(1'b0, 1'b0);
    idle();
    idle();

    // Fill A1..D4, then drain.
    wr(8'hA1); wr(8'hB2); wr(8'hC3); wr(8'hD4);
    rd(); rd(); rd(); rd();
    idle();

    // Overflow drop of EE, overrun flag, then drain 11..14.
    wr(8'h11); wr(8'h12); wr(8'h13); wr(8'h14);
    wr(8'hEE);
    idle();
    rd(); rd(); rd(); rd();

    // Simultaneous read/write while full, with wrap-around.
    wr(8'h21); wr(8'h22); wr(8'h23); wr(8'h24);
    rd_wr(8'h25);
    rd(); rd(); rd(); rd();

    // Empty read, then read+write on empty, then read 5A.
    rd();
    rd_wr(8'h5A);
    rd();
    rd();

    // Write from bus side is not a read.
    wr(8'h66);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    rd();

    // Reset mid-traffic with both strobes active.
    wr(8'h31); wr(8'h32);
    clear(1'b1, 1'b1);
    idle();
    rd();

    // Randomized traffic in phases of varying read/write pressure.
    for (int ph = 0; ph < 6; ph++) begin
      int wr_pct;
      int rd_pct;
      wr_pct = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 30 : 55;
      rd_pct = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 70 : 45;
      for (int i = 0; i < 300; i++) begin
        logic clr_b;
        logic ps;
        logic pw;
        logic rv;
        clr_b = ($urandom_range(0, 99) != 0);
        rv    = ($urandom_range(0, 99) < wr_pct);
        if ($urandom_range(0, 99) < rd_pct) begin
          ps = 1'b1;
          pw = 1'b0;
        end else begin
          ps = 1'($urandom_range(0, 1));
          pw = 1'b1;
        end
        step(clr_b, ps, pw, rv, 8'($urandom));
      end
    end

    idle();

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge PCLK);
    #1;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
